mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter for the single-port data RAM. Shares the RAM between the CPU memory path (MAR/MDR fetch, load, store) and the UART loader/DMA engine. Sequences each access through a fixed three-cycle handshake, applies round-robin priority on contention, and masks CPU requests while the core is halted.

## Interface

- AW, 16, address width
- DW, 16, data width
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- hlt  in  1  CPU halted; cpu_req is ignored while high
- cpu_req  in  1  CPU access request; level, held with cpu_we/addr/wdata stable until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DW  read data; registered, held until the next CPU read completes
- dma_req, dma_we, dma_addr, dma_wdata  in  1/1/AW/DW  same semantics for the DMA port
- dma_ack  out  1  one-cycle completion pulse
- dma_rdata  out  DW  registered, held until the next DMA read completes
- ram_addr  out  AW  RAM address; valid only in ACC
- ram_wdata  out  DW  RAM write data; valid only in ACC
- ram_we  out  1  RAM write strobe; single cycle in ACC
- ram_re  out  1  RAM read strobe; single cycle in ACC
- ram_rdata  in  DW  synchronous RAM read data; valid in the cycle after ram_re
- owner  out  2  00 none, 01 CPU, 10 DMA; current access owner in ACC/WAIT
- busy  out  1  high in ACC and WAIT

## Operation

- States: IDLE, ACC, WAIT.
- IDLE: arbitrates eligible requests.
  - cpu_req is eligible when hlt=0 and it was not acked in this cycle.
  - dma_req is eligible when it was not acked in this cycle.
  - One eligible request: grant it and go to ACC.
  - Both eligible: grant the port that was not last_owner, then go to ACC.
  - None eligible: stay in IDLE.
- ACC: drives ram_addr/ram_wdata from the granted port.
  - Asserts ram_we (write) or ram_re (read) for exactly one cycle.
  - Latches the granted port's we; later changes on the port are ignored.
  - Goes to WAIT.
- WAIT:
  - Read: ram_rdata is loaded into the owner's rdata register at the ending edge.
  - Write: no data capture.
  - Sets the owner's ack flop, updates last_owner, goes to IDLE.
- ack is registered and high for exactly the first IDLE cycle after WAIT.
- The acked port's req is masked from arbitration in that cycle, because the requester drops or reissues req only after sampling ack.
- The other port may win arbitration in the ack cycle, so two contending requesters alternate access by access.
- Addresses pass through unmodified; no wrap or translation.
- hlt rising during a CPU ACC/WAIT: the in-flight access completes and acks normally. No further CPU grants until hlt=0.
- Requests are never dropped or reordered. A req held high is granted within at most one other access (round-robin bound).
- Outputs are unregistered decodes of state/owner, except rdata, ack and last_owner.

## Timing

- Reset (reset=0, asynchronous): state=IDLE, owner=00, busy=0, ram_we=ram_re=0, ram_addr=ram_wdata=0, cpu_ack=dma_ack=0, cpu_rdata=dma_rdata=0, last_owner=DMA (so the CPU wins the first tie).
- Reset mid-access aborts immediately. A ram_we already sampled by the RAM is not undone. No ack is issued for an aborted access.
- Latency: req high in IDLE cycle N gives ACC in N+1, WAIT in N+2, and ack with valid rdata in N+3.
- Minimum period for the same port: 4 cycles (ack cycle masked, re-arbitrate in N+4, ACC in N+5).
- Throughput with both ports active: one access per 3 cycles, alternating ports.
- Simultaneous events:
  - A new req from one port and an ack to the other in the same cycle: the new req is arbitrated normally.
  - A req deasserted before grant is legal and is simply not served.

## Test plan

- CPU read alone: RAM[0x0010]=0xBEEF, cpu_req/addr=0x0010 at cycle 0 -> ram_re in cycle 1 only, cpu_ack in cycle 3, cpu_rdata=0xBEEF held after ack.
- DMA write then CPU read of the same address: dma writes 0x1234 to 0x0200, then cpu reads 0x0200 -> one ram_we cycle with ram_wdata=0x1234, CPU read returns 0x1234.
- Contention: both req high continuously from reset, 6 accesses -> grant order CPU, DMA, CPU, DMA, CPU, DMA, one access every 3 cycles, each ack exactly one cycle.
- Halt masking: hlt=1 with both req high -> only DMA served. Raise hlt during a CPU ACC -> that CPU access still acks, then CPU grants stop until hlt=0.
- Reset mid-access: assert reset in WAIT of a CPU read -> all outputs at reset values in the same cycle, no cpu_ack. After release with cpu_req still high, the access reissues and completes in 3 cycles.
- Back-to-back same port: DMA holds req for 3 reads of 0x0000..0x0002 -> ACC cycles spaced exactly 4 cycles apart, rdata matches RAM contents each time.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single-port data RAM between the CPU memory path and the UART
// loader / DMA engine. Each access runs through a fixed sequence:
//   IDLE (arbitrate) -> ACC (one RAM strobe) -> WAIT (capture) -> IDLE (+ack)
//
// Request/acknowledge handshake (both ports):
//   A requester raises req together with we/addr/wdata and holds all four
//   stable until it samples ack high. ack is a single-cycle registered pulse,
//   high in the first IDLE cycle after WAIT. In that cycle the acked port's
//   req is ignored, because the requester only drops or reissues req after it
//   has seen ack. The other port may be granted in the ack cycle, so two
//   busy requesters alternate access by access.
//
// Contention is resolved round-robin: on a tie the port that did not own the
// previous access wins. CPU requests are ignored while hlt is high; an access
// already granted to the CPU finishes normally.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   hlt                   CPU halted; masks cpu_req from arbitration
//   cpu_req/we/addr/wdata CPU request, held stable until cpu_ack
//   cpu_ack, cpu_rdata    completion pulse, registered read data (held)
//   dma_req/we/addr/wdata DMA request, held stable until dma_ack
//   dma_ack, dma_rdata    completion pulse, registered read data (held)
//   ram_addr/wdata        RAM address / write data, driven only in ACC
//   ram_we, ram_re        single-cycle RAM strobes in ACC
//   ram_rdata             synchronous RAM read data, valid the cycle after ram_re
//   owner                 00 none, 01 CPU, 10 DMA (ACC and WAIT only)
//   busy                  high in ACC and WAIT
//   dbg_state             current FSM state (00 IDLE, 01 ACC, 10 WAIT)
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          hlt,

  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,

  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,

  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  output logic          ram_re,
  input  logic [DW-1:0] ram_rdata,

  output logic [1:0]    owner,
  output logic          busy,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ACC  = 2'b01,
    ST_WAIT = 2'b10
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_DMA  = 2'b10;

  state_t state;
  logic   grant_dma;  // owner of the access in ACC/WAIT: 1 = DMA, 0 = CPU
  logic   acc_we;     // direction latched at grant; port changes are ignored
  logic   last_dma;   // owner of the most recently completed access

  logic   cpu_elig;
  logic   dma_elig;
  logic   pick_dma;

  // The ack flop is high exactly in the ack cycle, so it doubles as the
  // "acked this cycle" mask for the port's own request.
  assign cpu_elig = cpu_req & ~hlt & ~cpu_ack;
  assign dma_elig = dma_req & ~dma_ack;

  // DMA wins when it is the only eligible port, or on a tie when the CPU
  // owned the previous access.
  assign pick_dma = dma_elig & (~cpu_elig | ~last_dma);

  // ---------------------------------------------------------------------------
  // Sequencer: state, grant, latched direction, round-robin pointer, ack
  // pulses and read-data registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      grant_dma <= 1'b0;
      acc_we    <= 1'b0;
      last_dma  <= 1'b1;  // CPU wins the first tie after reset
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (cpu_elig || dma_elig) begin
            grant_dma <= pick_dma;
            acc_we    <= pick_dma ? dma_we : cpu_we;
            state     <= ST_ACC;
          end
        end

        ST_ACC: begin
          state <= ST_WAIT;
        end

        ST_WAIT: begin
          // ram_rdata belongs to the strobe issued in ACC one cycle earlier.
          if (!acc_we) begin
            if (grant_dma) begin
              dma_rdata <= ram_rdata;
            end else begin
              cpu_rdata <= ram_rdata;
            end
          end
          if (grant_dma) begin
            dma_ack <= 1'b1;
          end else begin
            cpu_ack <= 1'b1;
          end
          last_dma <= grant_dma;
          state    <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode. Address and write data come straight from the granted
  // port, which holds them stable until its ack; outside ACC the RAM bus is
  // parked at zero.
  // ---------------------------------------------------------------------------
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    if (state == ST_ACC) begin
      ram_addr  = grant_dma ? dma_addr  : cpu_addr;
      ram_wdata = grant_dma ? dma_wdata : cpu_wdata;
      ram_we    = acc_we;
      ram_re    = ~acc_we;
    end
  end

  always_comb begin
    busy  = (state == ST_ACC) || (state == ST_WAIT);
    owner = OWN_NONE;
    if (busy) begin
      owner = grant_dma ? OWN_DMA : OWN_CPU;
    end
  end

  assign dbg_state = state;

  // ---------------------------------------------------------------------------
  // Structural invariants of the sequencer.
  // ---------------------------------------------------------------------------
  a_strobe_excl : assert property (@(posedge clk) disable iff (!reset)
    !(ram_we && ram_re));

  a_ack_excl : assert property (@(posedge clk) disable iff (!reset)
    !(cpu_ack && dma_ack));

  a_ack_in_idle : assert property (@(posedge clk) disable iff (!reset)
    (cpu_ack || dma_ack) |-> (state == ST_IDLE));

  a_acc_to_wait : assert property (@(posedge clk) disable iff (!reset)
    (state == ST_ACC) |=> (state == ST_WAIT));

  a_wait_to_idle : assert property (@(posedge clk) disable iff (!reset)
    (state == ST_WAIT) |=> (state == ST_IDLE));

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Bench for mem_arbiter: a synchronous RAM model on the RAM side, directed
// scenarios for latency, ordering, halt masking, reset abort and back-to-back
// spacing, then a randomized two-port run checked against a transaction-level
// reference (shadow memory, per-port pending request, round-robin bound).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic          clk;
  logic          reset;
  logic          hlt;
  logic          cpu_req, cpu_we, cpu_ack;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dma_req, dma_we, dma_ack;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we, ram_re;
  logic [DW-1:0] ram_rdata = '0;
  logic [1:0]    owner;
  logic          busy;
  logic [1:0]    dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .hlt       (hlt),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_ack   (dma_ack),
    .dma_rdata (dma_rdata),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_re    (ram_re),
    .ram_rdata (ram_rdata),
    .owner     (owner),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Synchronous single-port RAM: read data appears the cycle after ram_re.
  logic [DW-1:0] ram_mem [0:65535];
  logic [DW-1:0] ref_mem [0:65535];

  always @(posedge clk) begin
    if (ram_re) ram_rdata <= ram_mem[ram_addr];
    if (ram_we) ram_mem[ram_addr] = ram_wdata;
  end

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [1:0]    exp_q[$];       // expected owner sequence
  logic [DW-1:0] exp_data_q[$];  // expected read data sequence

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
    ram_mem[a] = v;
    ref_mem[a] = v;
  endtask

  // Leaves the bench 1 unit after a rising edge with reset just released;
  // the current cycle is the first active cycle.
  task automatic do_reset();
    reset     = 1'b0;
    hlt       = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    dma_req   = 1'b0;
    dma_we    = 1'b0;
    dma_addr  = '0;
    dma_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",  busy,      0);
    check("rst_owner", owner,     0);
    check("rst_we",    ram_we,    0);
    check("rst_re",    ram_re,    0);
    check("rst_addr",  ram_addr,  0);
    check("rst_wdata", ram_wdata, 0);
    check("rst_cack",  cpu_ack,   0);
    check("rst_dack",  dma_ack,   0);
    check("rst_crd",   cpu_rdata, 0);
    check("rst_drd",   dma_rdata, 0);
    reset = 1'b1;
  endtask

  // One access on one port with the other idle. Returns the cycle of the ack
  // (relative to the cycle req was raised), strobe counts and read data.
  task automatic single_access(input bit is_dma, input bit we,
                               input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                               output logic [DW-1:0] rd, output int lat,
                               output int n_we, output int n_re, output int first_strobe);
    rd = '0; lat = -1; n_we = 0; n_re = 0; first_strobe = -1;
    if (is_dma) begin
      dma_we = we; dma_addr = addr; dma_wdata = wd; dma_req = 1'b1;
    end else begin
      cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_req = 1'b1;
    end
    for (int c = 0; c < 20 && lat < 0; c++) begin
      sample();
      if (ram_re || ram_we) begin
        if (first_strobe < 0) first_strobe = c;
        check("sa_addr", ram_addr, addr);
        check("sa_owner", owner, is_dma ? 2'b10 : 2'b01);
        if (ram_we) check("sa_wdata", ram_wdata, wd);
      end
      if (ram_re) n_re++;
      if (ram_we) n_we++;
      if (is_dma ? dma_ack : cpu_ack) begin
        lat = c;
        rd  = is_dma ? dma_rdata : cpu_rdata;
      end else begin
        next_cycle();
      end
    end
    next_cycle();
    if (is_dma) dma_req = 1'b0;
    else        cpu_req = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [DW-1:0] rd;
  int            lat, n_we, n_re, fst;

  // randomized phase state, index 0 = CPU, 1 = DMA
  bit            act[2], rwe[2], ack_seen[2];
  logic [AW-1:0] raddr[2];
  logic [DW-1:0] rwd[2];
  int            strobe_at[2], bypass[2], waitc[2], served[2];
  bit            prev_hlt;

  initial begin
    reset = 1'b0;
    for (int i = 0; i < 65536; i++) begin
      ram_mem[i] = DW'(i * 7 + 3);
      ref_mem[i] = DW'(i * 7 + 3);
    end

    // ---- CPU read alone -----------------------------------------------------
    preload(16'h0010, 16'hBEEF);
    do_reset();
    single_access(1'b0, 1'b0, 16'h0010, '0, rd, lat, n_we, n_re, fst);
    check("rd_latency", lat, 3);
    check("rd_strobe_cycle", fst, 1);
    check("rd_re_count", n_re, 1);
    check("rd_we_count", n_we, 0);
    check("rd_data", rd, 16'hBEEF);
    sample();
    check("rd_ack_single", cpu_ack, 0);
    check("rd_data_held", cpu_rdata, 16'hBEEF);

    // ---- DMA write then CPU read of the same address ------------------------
    next_cycle();
    single_access(1'b1, 1'b1, 16'h0200, 16'h1234, rd, lat, n_we, n_re, fst);
    check("wr_latency", lat, 3);
    check("wr_we_count", n_we, 1);
    check("wr_re_count", n_re, 0);
    ref_mem[16'h0200] = 16'h1234;
    single_access(1'b0, 1'b0, 16'h0200, '0, rd, lat, n_we, n_re, fst);
    check("wr_rd_latency", lat, 3);
    check("wr_rd_data", rd, 16'h1234);

    // ---- Contention from reset: CPU, DMA, CPU, ... every 3 cycles ----------
    do_reset();
    for (int k = 0; k < 6; k++) exp_q.push_back((k % 2 == 0) ? 2'b01 : 2'b10);
    cpu_we = 1'b0; cpu_addr = 16'h0020; cpu_req = 1'b1;
    dma_we = 1'b0; dma_addr = 16'h0021; dma_req = 1'b1;
    for (int c = 0; c < 18; c++) begin
      sample();
      check("cont_strobe", ram_re, (c % 3) == 1);
      check("cont_busy", busy, (c % 3) != 0);
      if (ram_re) begin
        check("cont_q_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("cont_owner", owner, exp_q.pop_front());
      end
      check("cont_cack", cpu_ack, (c > 0) && (c % 3 == 0) && ((c / 3 - 1) % 2 == 0));
      check("cont_dack", dma_ack, (c > 0) && (c % 3 == 0) && ((c / 3 - 1) % 2 == 1));
      next_cycle();
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
    check("cont_q_drained", exp_q.size(), 0);
    repeat (3) next_cycle();

    // ---- Halt masking --------------------------------------------------------
    preload(16'h0040, 16'h7777);
    do_reset();
    begin
      int n_dack, n_cack, n_cpu_own, n_busy;
      n_dack = 0; n_cack = 0; n_cpu_own = 0; n_busy = 0;
      hlt = 1'b1;
      cpu_we = 1'b0; cpu_addr = 16'h0040; cpu_req = 1'b1;
      dma_we = 1'b0; dma_addr = 16'h0041; dma_req = 1'b1;
      for (int c = 0; c < 12; c++) begin
        sample();
        if (dma_ack) n_dack++;
        if (cpu_ack) n_cack++;
        if (owner == 2'b01) n_cpu_own++;
        next_cycle();
      end
      check("hlt_dma_acks", n_dack, 3);
      check("hlt_cpu_acks", n_cack, 0);
      check("hlt_cpu_owner", n_cpu_own, 0);
      // release hlt for one grant, then raise it during the CPU ACC
      dma_req = 1'b0;
      hlt = 1'b0;
      sample();
      check("hlt_idle", busy, 0);
      next_cycle();
      hlt = 1'b1;
      sample();
      check("hlt_acc_re", ram_re, 1);
      check("hlt_acc_owner", owner, 2'b01);
      next_cycle();
      next_cycle();
      sample();
      check("hlt_inflight_ack", cpu_ack, 1);
      check("hlt_inflight_data", cpu_rdata, 16'h7777);
      for (int c = 0; c < 8; c++) begin
        next_cycle();
        sample();
        if (busy) n_busy++;
      end
      check("hlt_no_grant", n_busy, 0);
      next_cycle();
      hlt = 1'b0;
      sample();
      check("hlt_release_idle", busy, 0);
      next_cycle();
      sample();
      check("hlt_release_re", ram_re, 1);
      next_cycle();
      next_cycle();
      sample();
      check("hlt_release_ack", cpu_ack, 1);
      next_cycle();
      cpu_req = 1'b0;
    end

    // ---- Reset in WAIT of a CPU read ----------------------------------------
    preload(16'h0030, 16'hA5A5);
    do_reset();
    cpu_we = 1'b0; cpu_addr = 16'h0030; cpu_req = 1'b1;
    sample();
    next_cycle();
    sample();
    check("ra_acc", ram_re, 1);
    next_cycle();
    sample();
    check("ra_wait_busy", busy, 1);
    #1 reset = 1'b0;
    #1;
    check("ra_busy",  busy,      0);
    check("ra_owner", owner,     0);
    check("ra_re",    ram_re,    0);
    check("ra_addr",  ram_addr,  0);
    check("ra_cack",  cpu_ack,   0);
    check("ra_crd",   cpu_rdata, 0);
    @(posedge clk);
    #1;
    check("ra_no_ack", cpu_ack, 0);
    reset = 1'b1;
    single_access(1'b0, 1'b0, 16'h0030, '0, rd, lat, n_we, n_re, fst);
    check("ra_reissue_latency", lat, 3);
    check("ra_reissue_re", n_re, 1);
    check("ra_reissue_data", rd, 16'hA5A5);

    // ---- Back-to-back DMA reads of 0x0000..0x0002 ---------------------------
    do_reset();
    for (int i = 0; i < 3; i++) begin
      logic [DW-1:0] v;
      v = DW'($urandom);
      preload(AW'(i), v);
      exp_data_q.push_back(v);
    end
    begin
      int idx, last_acc;
      bit got_ack;
      idx = 0; last_acc = -1;
      dma_we = 1'b0; dma_addr = '0; dma_req = 1'b1;
      for (int c = 0; c < 16; c++) begin
        sample();
        got_ack = dma_ack;
        if (ram_re) begin
          if (last_acc >= 0) check("b2b_gap", c - last_acc, 4);
          else               check("b2b_first", c, 1);
          check("b2b_addr", ram_addr, idx);
          last_acc = c;
        end
        if (dma_ack) begin
          check("b2b_q_nonempty", exp_data_q.size() != 0, 1);
          if (exp_data_q.size() != 0) check("b2b_data", dma_rdata, exp_data_q.pop_front());
        end
        next_cycle();
        if (got_ack) begin
          idx++;
          if (idx < 3) dma_addr = AW'(idx);
          else         dma_req  = 1'b0;
        end
      end
      check("b2b_count", idx, 3);
      check("b2b_q_drained", exp_data_q.size(), 0);
    end

    // ---- Randomized two-port traffic ----------------------------------------
    do_reset();
    for (int i = 0; i < 16; i++) preload(AW'(i), DW'($urandom));
    for (int p = 0; p < 2; p++) begin
      act[p] = 0; ack_seen[p] = 0; strobe_at[p] = -1;
      bypass[p] = 0; waitc[p] = 0; served[p] = 0;
    end
    prev_hlt = 1'b0;
    for (int cyc = 0; cyc < 3060; cyc++) begin
      bit draining;
      draining = (cyc >= 3000);
      for (int p = 0; p < 2; p++) begin
        if (ack_seen[p]) begin
          act[p] = 0;
          ack_seen[p] = 0;
        end
        if (!act[p] && !draining && $urandom_range(0, 3) == 0) begin
          act[p]       = 1;
          rwe[p]       = 1'($urandom_range(0, 1));
          raddr[p]     = AW'($urandom_range(0, 15));
          rwd[p]       = DW'($urandom);
          strobe_at[p] = -1;
          bypass[p]    = 0;
          waitc[p]     = 0;
        end
      end
      if (draining)                        hlt = 1'b0;
      else if ($urandom_range(0, 15) == 0) hlt = ~hlt;
      cpu_req = act[0]; cpu_we = rwe[0]; cpu_addr = raddr[0]; cpu_wdata = rwd[0];
      dma_req = act[1]; dma_we = rwe[1]; dma_addr = raddr[1]; dma_wdata = rwd[1];

      sample();
      if (ram_we || ram_re) begin
        int p, q;
        p = (owner == 2'b10) ? 1 : 0;
        q = 1 - p;
        check("rnd_owner_valid", (owner == 2'b01) || (owner == 2'b10), 1);
        check("rnd_owner_pending", act[p] && (strobe_at[p] < 0), 1);
        check("rnd_addr", ram_addr, raddr[p]);
        check("rnd_dir", ram_we, rwe[p]);
        if (ram_we) check("rnd_wdata", ram_wdata, rwd[p]);
        if (p == 0) check("rnd_cpu_grant_halted", prev_hlt, 0);
        check("rnd_wait_bound", waitc[p] <= 12, 1);
        strobe_at[p] = cyc;
        if (act[q] && strobe_at[q] < 0) begin
          bypass[q]++;
          check("rnd_rr_bound", bypass[q] <= 1, 1);
        end
      end
      for (int p = 0; p < 2; p++) begin
        bit ackv;
        ackv = (p == 1) ? dma_ack : cpu_ack;
        if (act[p] && strobe_at[p] >= 0 && cyc - strobe_at[p] == 2)
          check("rnd_ack_due", ackv, 1);
        if (ackv) begin
          check("rnd_ack_latency", act[p] && (cyc - strobe_at[p] == 2), 1);
          if (act[p]) begin
            if (!rwe[p]) check("rnd_rdata", (p == 1) ? dma_rdata : cpu_rdata, ref_mem[raddr[p]]);
            else         ref_mem[raddr[p]] = rwd[p];
            ack_seen[p] = 1;
            served[p]++;
          end
        end
        if (act[p] && strobe_at[p] < 0) waitc[p]++;
      end
      if (hlt) begin
        waitc[0]  = 0;
        bypass[0] = 0;
      end
      prev_hlt = hlt;
      next_cycle();
    end
    for (int p = 0; p < 2; p++) if (ack_seen[p]) act[p] = 0;
    check("rnd_cpu_drained", act[0], 0);
    check("rnd_dma_drained", act[1], 0);
    check("rnd_cpu_served", served[0] > 20, 1);
    check("rnd_dma_served", served[1] > 20, 1);
    cpu_req = 1'b0;
    dma_req = 1'b0;
    repeat (3) next_cycle();

    // ---- Final report --------------------------------------------------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
